// File: rtl/ice40_reset_seq_pkg.sv
// Shared types and constants for the iCE40 reset sequencer.
// Also holds the SB_WARMBOOT image encodings.
package ice40_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN,
    BOOT
  } reset_seq_state_t;

  localparam logic [1:0] IMG_0 = 2'b00;
  localparam logic [1:0] IMG_1 = 2'b01;
  localparam logic [1:0] IMG_2 = 2'b10;
  localparam logic [1:0] IMG_3 = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ice40_reset_seq.sv
// Power-on / soft reset sequencer with staggered release of NRST resets,
// plus warm-boot sequencing towards SB_WARMBOOT.
module ice40_reset_seq
  import ice40_pkg::*;
#(
  parameter int NRST        = 3,
  parameter int HOLD_CYCLES = 240,
  parameter int STAGE_GAP   = 16,
  parameter int BOOT_DELAY  = 24
) (
  input  logic            clk_24,
  input  logic            rst_24,
  input  logic            soft_rst_req,
  input  logic            boot_req,
  input  logic [1:0]      boot_image,
  output logic [NRST-1:0] rst_out,
  output logic            ready,
  output logic            boot,
  output logic [1:0]      image
);

  localparam int CNT_W = $clog2(max3(HOLD_CYCLES, NRST * STAGE_GAP, BOOT_DELAY) + 1);

  if (NRST < 1)        begin : g_bad_nrst  $error("NRST must be >= 1");        end
  if (HOLD_CYCLES < 1) begin : g_bad_hold  $error("HOLD_CYCLES must be >= 1"); end
  if (STAGE_GAP < 1)   begin : g_bad_gap   $error("STAGE_GAP must be >= 1");   end
  if (BOOT_DELAY < 1)  begin : g_bad_delay $error("BOOT_DELAY must be >= 1");  end

  reset_seq_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [NRST-1:0]  rst_reg, rst_next;
  logic             ready_reg, ready_next;
  logic             boot_reg, boot_next;
  logic [1:0]       image_reg, image_next;
  logic [1:0]       image_sel;
  logic [NRST-1:0]  stage_hit;

  // In RELEASE the counter runs across all stages; bit gi drops when it
  // reaches gi*STAGE_GAP-1, which keeps rst_out thermometer-shaped.
  assign stage_hit[0] = 1'b0;
  for (genvar gi = 1; gi < NRST; gi++) begin : g_stage
    assign stage_hit[gi] = (state_reg == RELEASE) &&
                           (cnt_reg == CNT_W'(gi * STAGE_GAP - 1));
  end

  always_comb begin
    image_sel = IMG_0;
    case (boot_image)
      2'd1:    image_sel = IMG_1;
      2'd2:    image_sel = IMG_2;
      2'd3:    image_sel = IMG_3;
      default: image_sel = IMG_0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rst_next   = rst_reg;
    ready_next = ready_reg;
    boot_next  = boot_reg;
    image_next = image_reg;

    if (state_reg != BOOT && boot_req) begin
      state_next = BOOT;
      cnt_next   = '0;
      rst_next   = '1;
      ready_next = 1'b0;
      image_next = image_sel;
    end else if (state_reg != BOOT && soft_rst_req) begin
      state_next = HOLD;
      cnt_next   = '0;
      rst_next   = '1;
      ready_next = 1'b0;
    end else begin
      case (state_reg)
        HOLD: begin
          if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
            rst_next[0] = 1'b0;
            cnt_next    = '0;
            if (NRST == 1) begin
              ready_next = 1'b1;
              state_next = RUN;
            end else begin
              state_next = RELEASE;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        RELEASE: begin
          rst_next = rst_reg & ~stage_hit;
          cnt_next = cnt_reg + 1'b1;
          if (stage_hit[NRST-1]) begin
            ready_next = 1'b1;
            cnt_next   = '0;
            state_next = RUN;
          end
        end
        RUN: begin
          cnt_next = '0;
        end
        BOOT: begin
          // Once boot is raised the counter parks; only rst_24 leaves BOOT.
          if (!boot_reg) begin
            if (cnt_reg == CNT_W'(BOOT_DELAY - 1)) begin
              boot_next = 1'b1;
              cnt_next  = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = HOLD;
          cnt_next   = '0;
          rst_next   = '1;
          ready_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_24) begin
    if (rst_24) begin
      state_reg <= HOLD;
      cnt_reg   <= '0;
      rst_reg   <= '1;
      ready_reg <= 1'b0;
      boot_reg  <= 1'b0;
      image_reg <= IMG_0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rst_reg   <= rst_next;
      ready_reg <= ready_next;
      boot_reg  <= boot_next;
      image_reg <= image_next;
    end
  end

  assign rst_out = rst_reg;
  assign ready   = ready_reg;
  assign boot    = boot_reg;
  assign image   = image_reg;

endmodule
